// File: rtl/conv_acc_pkg.sv
// conv_acc_pkg: shared geometry, widths and types for the OFM collector slice.
//   - Output-map geometry: tile width, tiles per band, band height, traversed rows,
//     and stored height/width.
//   - FIFO entry type: a packed address and data pair.
//   - ofm_addr(): linear OFM address oc*H*W + row*W + col, truncated to ADDR_W bits.
package conv_acc_pkg;

  localparam int OUT_DW     = 25;
  localparam int TI         = 16;
  localparam int TW_N       = 4;
  localparam int BAND_ROWS  = 5;
  localparam int ROW_SPAN   = 65;
  localparam int OFM_H      = 61;
  localparam int OFM_W      = 61;
  localparam int ADDR_W     = 16;
  localparam int FIFO_DEPTH = 8;

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int OC_W    = 6;               // holds n_co up to 32
  localparam int OH_W    = 8;
  localparam int OW_W    = $clog2(TI);
  localparam int TW_W    = $clog2(TW_N);
  localparam int TH_W    = 4;
  localparam int COL_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } layer_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [OUT_DW-1:0] data;
  } ofm_entry_t;

  // The address is built at 32 bits and then truncated, so large channel indices
  // wrap modulo 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] ofm_addr(input logic [OC_W-1:0]  oc,
                                                 input logic [OH_W-1:0]  row,
                                                 input logic [COL_W-1:0] col);
    logic [31:0] full;
    full = 32'(oc) * 32'(OFM_H * OFM_W) + 32'(row) * 32'(OFM_W) + 32'(col);
    return full[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/ofm_fifo2w.sv
// ofm_fifo2w: FIFO that accepts up to two pushes and one pop per cycle.
//   clk, rst_n        : clock and asynchronous active-low reset
//   clr               : synchronous flush; also clears the sticky overflow flag
//   push0/entry0      : first push of the cycle (it has priority for space)
//   push1/entry1      : second push of the cycle
//   pop_ready         : the sink takes the head this cycle if head_valid is set
//   head_valid/head   : registered head of the queue
//   empty             : queue holds no entries
//   overflow          : sticky flag, set when a push is dropped for lack of space
module ofm_fifo2w
  import conv_acc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       push0,
  input  ofm_entry_t entry0,
  input  logic       push1,
  input  ofm_entry_t entry1,
  input  logic       pop_ready,
  output logic       head_valid,
  output ofm_entry_t head,
  output logic       empty,
  output logic       overflow
);

  localparam int CNT_W = FIFO_AW + 1;

  ofm_entry_t         mem_q [FIFO_DEPTH];
  ofm_entry_t         mem_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr1_s;
  logic [CNT_W-1:0]   count_q, count_d, count_pop_s, free_s;
  logic               head_valid_q, head_valid_d;
  ofm_entry_t         head_q, head_d;
  logic               overflow_q, overflow_d;
  logic               pop_s, acc0_s, acc1_s, drop_s;
  logic [1:0]         n_acc_s;
  ofm_entry_t         first_s;

  // Admission, storage and next-head selection. A pop in this cycle frees its slot
  // for this cycle's pushes. Port0 claims space first, so port1 is dropped first.
  always_comb begin
    pop_s       = head_valid_q & pop_ready;
    count_pop_s = count_q - CNT_W'(pop_s);
    free_s      = CNT_W'(FIFO_DEPTH) - count_pop_s;
    acc0_s      = push0 & (free_s != {CNT_W{1'b0}});
    if (push0) begin
      acc1_s = push1 & (free_s >= CNT_W'(2));
    end else begin
      acc1_s = push1 & (free_s != {CNT_W{1'b0}});
    end
    n_acc_s   = {1'b0, acc0_s} + {1'b0, acc1_s};
    first_s   = acc0_s ? entry0 : entry1;
    drop_s    = (push0 & ~acc0_s) | (push1 & ~acc1_s);
    wr_ptr1_s = wr_ptr_q + FIFO_AW'(1);
    mem_d     = mem_q;
    if (clr) begin
      wr_ptr_d     = {FIFO_AW{1'b0}};
      rd_ptr_d     = {FIFO_AW{1'b0}};
      count_d      = {CNT_W{1'b0}};
      overflow_d   = 1'b0;
      head_valid_d = 1'b0;
      head_d       = '0;
    end else begin
      if (acc0_s | acc1_s) begin
        mem_d[wr_ptr_q] = first_s;
      end else begin
        mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
      end
      if (acc0_s & acc1_s) begin
        mem_d[wr_ptr1_s] = entry1;
      end else begin
        mem_d[wr_ptr1_s] = mem_q[wr_ptr1_s];
      end
      wr_ptr_d   = wr_ptr_q + FIFO_AW'(n_acc_s);
      rd_ptr_d   = rd_ptr_q + FIFO_AW'(pop_s);
      count_d    = count_pop_s + CNT_W'(n_acc_s);
      overflow_d = overflow_q | drop_s;
      // The head is registered: it is either an entry that was already queued or,
      // when the queue drains to nothing this cycle, the first entry pushed now.
      if (count_d == {CNT_W{1'b0}}) begin
        head_valid_d = 1'b0;
        head_d       = '0;
      end else if (count_pop_s != {CNT_W{1'b0}}) begin
        head_valid_d = 1'b1;
        head_d       = mem_q[rd_ptr_d];
      end else begin
        head_valid_d = 1'b1;
        head_d       = first_s;
      end
    end
  end

  // State registers for the queue storage, pointers and head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= {FIFO_AW{1'b0}};
      rd_ptr_q     <= {FIFO_AW{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      overflow_q   <= 1'b0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  assign head_valid = head_valid_q;
  assign head       = head_q;
  assign empty      = ~head_valid_q;
  assign overflow   = overflow_q;

endmodule

// File: rtl/ofm_collector.sv
// ofm_collector: turns the CONV_ACC two-row output stream into linear OFM writes.
//   start, cfg_co        : begin or restart a layer; channels = (cfg_co+1)*8
//   ofm_port0/_v         : element for row oh; ofm_port1/_v: element for row oh+1
//   end_op               : CONV_ACC reports that the layer is complete (level)
//   wr_valid/wr_ready    : write handshake toward the OFM buffer; wr_addr and
//                          wr_data come from the registered FIFO head
//   busy, done           : layer status
//   overflow, proto_err  : sticky error flags, cleared by start
// Optional build macro OFM_RELU_EN: negative elements are written as zero.
module ofm_collector
  import conv_acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cfg_co,
  input  logic [OUT_DW-1:0] ofm_port0,
  input  logic [OUT_DW-1:0] ofm_port1,
  input  logic              ofm_port0_v,
  input  logic              ofm_port1_v,
  input  logic              end_op,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [OUT_DW-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              proto_err
);

  layer_state_e      state_q, state_d;
  logic [OC_W-1:0]   n_co_q, n_co_d, oc_q, oc_d;
  logic [OH_W-1:0]   oh_q, oh_d, row1_s, oh_nx_s;
  logic [OW_W-1:0]   ow_q, ow_d;
  logic [TW_W-1:0]   tw_q, tw_d;
  logic [TH_W-1:0]   th_q, th_d, th_sum_s, row_step_s;
  logic              end_lat_q, end_lat_d;
  logic              proto_err_q, proto_err_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              any_v_s, dual_s, legal_s, advance_s, illegal_s, band_err_s;
  logic              push0_s, push1_s, fifo_empty_s, fifo_valid_s, fifo_ovf_s;
  logic [COL_W-1:0]  col_s;
  logic [OUT_DW-1:0] data0_s, data1_s;
  ofm_entry_t        entry0_s, entry1_s, head_s;

  // Validate the valid pattern, crop out-of-map elements and build FIFO entries.
  always_comb begin
    any_v_s   = ofm_port0_v | ofm_port1_v;
    dual_s    = ofm_port0_v & ofm_port1_v;
    legal_s   = busy_q & (oc_q != n_co_q) & ~(ofm_port1_v & ~ofm_port0_v);
    advance_s = any_v_s & legal_s & ~start;
    illegal_s = any_v_s & ~legal_s & ~start;
    col_s     = COL_W'(ow_q) + COL_W'(tw_q) * COL_W'(TI);
    row1_s    = oh_q + OH_W'(1);
    push0_s   = advance_s & ofm_port0_v & (oh_q < OH_W'(OFM_H)) & (col_s < COL_W'(OFM_W));
    push1_s   = advance_s & dual_s & (row1_s < OH_W'(OFM_H)) & (col_s < COL_W'(OFM_W));
`ifdef OFM_RELU_EN
    data0_s = ofm_port0[OUT_DW-1] ? {OUT_DW{1'b0}} : ofm_port0;
    data1_s = ofm_port1[OUT_DW-1] ? {OUT_DW{1'b0}} : ofm_port1;
`else
    data0_s = ofm_port0;
    data1_s = ofm_port1;
`endif
    entry0_s.addr = ofm_addr(oc_q, oh_q, col_s);
    entry0_s.data = data0_s;
    entry1_s.addr = ofm_addr(oc_q, row1_s, col_s);
    entry1_s.data = data1_s;
  end

  // Traversal counters: columns within a tile, rows within a band, tiles across a
  // band, bands down a channel. Crop does not stop the counters.
  always_comb begin
    ow_d       = ow_q;
    oh_d       = oh_q;
    tw_d       = tw_q;
    th_d       = th_q;
    oc_d       = oc_q;
    band_err_s = 1'b0;
    row_step_s = dual_s ? TH_W'(2) : TH_W'(1);
    th_sum_s   = th_q + row_step_s;
    oh_nx_s    = oh_q + OH_W'(row_step_s);
    if (start) begin
      ow_d = {OW_W{1'b0}};
      oh_d = {OH_W{1'b0}};
      tw_d = {TW_W{1'b0}};
      th_d = {TH_W{1'b0}};
      oc_d = {OC_W{1'b0}};
    end else if (advance_s && (ow_q == OW_W'(TI - 1))) begin
      ow_d = {OW_W{1'b0}};
      th_d = th_sum_s;
      if (th_sum_s >= TH_W'(BAND_ROWS)) begin
        // A band that overshoots its height is a protocol error; the excess
        // rows are carried into the next band's row count.
        band_err_s = (th_sum_s != TH_W'(BAND_ROWS));
        th_d       = th_sum_s - TH_W'(BAND_ROWS);
        if (tw_q == TW_W'(TW_N - 1)) begin
          // Last tile of the band: stay on the advanced row, which starts the next band.
          tw_d = {TW_W{1'b0}};
        end else begin
          // Another tile of the same band: go back up to its top row.
          tw_d    = tw_q + TW_W'(1);
          oh_nx_s = oh_nx_s - OH_W'(BAND_ROWS);
        end
      end else begin
        tw_d = tw_q;
      end
      if (oh_nx_s == OH_W'(ROW_SPAN)) begin
        oh_d = {OH_W{1'b0}};
        oc_d = oc_q + OC_W'(1);
      end else begin
        oh_d = oh_nx_s;
      end
    end else if (advance_s) begin
      ow_d = ow_q + OW_W'(1);
    end else begin
      ow_d = ow_q;
    end
  end

  // Layer status: a latched end_op completes the layer once the FIFO has drained.
  always_comb begin
    state_d     = state_q;
    n_co_d      = n_co_q;
    end_lat_d   = end_lat_q;
    proto_err_d = proto_err_q;
    if (start) begin
      state_d     = ST_RUN;
      n_co_d      = {({1'b0, cfg_co} + 3'd1), 3'b000};
      end_lat_d   = 1'b0;
      proto_err_d = 1'b0;
    end else begin
      proto_err_d = proto_err_q | illegal_s | band_err_s;
      case (state_q)
        ST_RUN: begin
          if (end_op) begin
            end_lat_d = 1'b1;
          end else begin
            end_lat_d = end_lat_q;
          end
          if (end_lat_q && fifo_empty_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_IDLE: state_d = ST_IDLE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // All control and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n_co_q      <= {OC_W{1'b0}};
      oc_q        <= {OC_W{1'b0}};
      oh_q        <= {OH_W{1'b0}};
      ow_q        <= {OW_W{1'b0}};
      tw_q        <= {TW_W{1'b0}};
      th_q        <= {TH_W{1'b0}};
      end_lat_q   <= 1'b0;
      proto_err_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_co_q      <= n_co_d;
      oc_q        <= oc_d;
      oh_q        <= oh_d;
      ow_q        <= ow_d;
      tw_q        <= tw_d;
      th_q        <= th_d;
      end_lat_q   <= end_lat_d;
      proto_err_q <= proto_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  ofm_fifo2w u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start),
    .push0      (push0_s),
    .entry0     (entry0_s),
    .push1      (push1_s),
    .entry1     (entry1_s),
    .pop_ready  (wr_ready),
    .head_valid (fifo_valid_s),
    .head       (head_s),
    .empty      (fifo_empty_s),
    .overflow   (fifo_ovf_s)
  );

  assign wr_valid  = fifo_valid_s;
  assign wr_addr   = head_s.addr;
  assign wr_data   = head_s.data;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = fifo_ovf_s;
  assign proto_err = proto_err_q;

endmodule

// File: doc/ofm_collector.md
Name: ofm_collector

Overview:
- Sits directly downstream of CONV_ACC and consumes its ofm_port0/ofm_port1 output stream.
- Tracks the tile traversal order (column tiles of TI, row bands of 5, channels) and converts each valid output element into a linear OFM memory address.
- Crops padding columns and rows, buffers results in a 2-in/1-out FIFO, and emits a single valid/ready write stream toward the OFM buffer.

Parameters:
OUT_DW, 25, output element width (matches CONV_ACC out_data_width)
TI, 16, columns per tile
TW_N, 4, tiles per band (64/TI)
BAND_ROWS, 5, rows per band
ROW_SPAN, 65, traversed rows per channel (13 bands x 5)
OFM_H, 61, stored rows; rows >= OFM_H are dropped
OFM_W, 61, stored columns; columns >= OFM_W are dropped
ADDR_W, 16, write address width
FIFO_DEPTH, 8, FIFO entries (power of two)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: clear counters and flags, begin a layer
cfg_co  in  2  output channels = (cfg_co+1)*8, sampled on start
ofm_port0  in  OUT_DW  element, row oh
ofm_port1  in  OUT_DW  element, row oh+1
ofm_port0_v  in  1  port0 valid
ofm_port1_v  in  1  port1 valid (only together with port0_v)
end_op  in  1  CONV_ACC layer complete (level)
wr_valid  out  1  write request
wr_ready  in  1  sink accepts
wr_addr  out  ADDR_W  oc*OFM_H*OFM_W + oh*OFM_W + col
wr_data  out  OUT_DW  signed element
busy  out  1  layer in progress
done  out  1  end_op seen and FIFO drained
overflow  out  1  sticky: element dropped because FIFO was full
proto_err  out  1  sticky: illegal valid pattern

Behaviour:
- Reset: all counters 0; FIFO empty; wr_valid, busy, done, overflow and proto_err 0; wr_addr and wr_data 0. Reset is asynchronous and may occur mid-layer; all state is lost.
- start: clears oc, oh, ow, tw and thcnt, the FIFO, done, overflow and proto_err; sets busy; latches n_co = (cfg_co+1)*8. A start during busy restarts the layer.
- Counters: col = ow + tw*TI.
  - Dual (port0_v and port1_v): elements go to (oh, col) then (oh+1, col); ow++. When ow reaches TI: ow=0, oh+=2, thcnt+=2.
  - Single (port0_v only): element goes to (oh, col); ow++. When ow reaches TI: ow=0, oh++, thcnt++.
  - Band completion, checked after either row-completion: if thcnt==5, then thcnt=0, tw++, oh-=5; if tw then equals TW_N, tw=0 and oh+=5. If thcnt would exceed 5, set proto_err and take thcnt=thcnt-5.
  - Channel completion: if oh==ROW_SPAN, then oh=0 and oc++.
- Illegal valid patterns: port1_v without port0_v, or any valid while oc==n_co or while busy==0 -> set proto_err and drop the element.
- Crop: an element with row >= OFM_H or col >= OFM_W is not pushed. Counters still advance.
- FIFO: up to 2 pushes per cycle, port0 before port1, 1 pop per cycle.
  - A pop in the same cycle frees space for that cycle's pushes.
  - Pushes that do not fit are dropped in order (port1 first) and set overflow.
  - There is no backpressure to CONV_ACC.
- Latency: valid sampled at edge N -> wr_valid asserted after edge N with the head entry. wr_addr and wr_data are registered FIFO head, stable while wr_valid && !wr_ready.
- end_op: latched while busy. done=1 and busy=0 once the latch is set and the FIFO is empty. done holds until start or reset.
- Arithmetic: address computed in ADDR_W bits and truncated if it exceeds that width. Data is passed unchanged unless the optional feature is enabled.

Optional Feature:
OFM_RELU_EN
- Defined: negative elements (MSB=1) are replaced by 0 before the push. Crop and address logic are unchanged.
- Undefined: data passes bit-exact.

Decomposition:
- Package conv_acc_pkg holds OUT_DW, TI, TW_N, BAND_ROWS, ROW_SPAN, OFM_H, OFM_W and the address-compute function.
- Sub-module ofm_fifo2w: 2-push/1-pop FIFO with the drop/overflow logic. The top level keeps the counters and control.

Test Plan:
1. Reset, start with cfg_co=0; 16 single valids with data 1..16 -> 16 writes, addresses 0..15, data 1..16; ow wraps to 0; oh=1.
2. Dual valids for 16 cycles (p0=k, p1=100+k), wr_ready=1 -> 32 writes alternating addresses k and 61+k; oh=2, thcnt=2.
3. Drive a full band (5 rows x 4 tiles) -> after tile 3, oh=5 and tw=0; tile 3 columns 61..63 produce no writes (3 crops per row, 15 total).
4. Hold wr_ready=0 and issue 5 dual valids -> exactly 8 entries stored, overflow=1, and the last 2 elements (one dual cycle) are dropped.
5. Feed one channel fully (65 rows) -> oc=1; element (oh=0, col=0) of channel 1 goes to address 3721. Assert end_op with 3 entries queued -> done rises the cycle after the third pop.
6. port1_v without port0_v -> proto_err=1 and no write. Under OFM_RELU_EN, input -5 is written as 0.
